// File: rtl/voxel_raster_if.sv
// ----------------------------------------------------------------------------
// voxel_raster_if
// Bundles the two buses of the voxel rasteriser:
//   - host voxel-store write port : vox_we, vox_waddr {z,y,x}, vox_wdata
//   - framebuffer write handshake : fb_we, fb_addr, fb_data out, fb_ready back
// Modports:
//   master : the rasteriser (sinks voxel writes, drives framebuffer writes)
//   slave  : the host / framebuffer side
// ----------------------------------------------------------------------------
interface voxel_raster_if #(
    parameter int GRID_BITS = 3,
    parameter int ADDR_W    = 12,
    parameter int COLOR_W   = 8
);
    logic                     vox_we;
    logic [3*GRID_BITS-1:0]   vox_waddr;
    logic [COLOR_W-1:0]       vox_wdata;

    logic                     fb_we;
    logic [ADDR_W-1:0]        fb_addr;
    logic [COLOR_W-1:0]       fb_data;
    logic                     fb_ready;

    modport master (
        input  vox_we, vox_waddr, vox_wdata, fb_ready,
        output fb_we, fb_addr, fb_data
    );

    modport slave (
        output vox_we, vox_waddr, vox_wdata, fb_ready,
        input  fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/voxel_raster.sv
// ----------------------------------------------------------------------------
// voxel_raster
// Orthographic ray-caster over an N x N x N voxel store (N = 2^GRID_BITS).
// For every framebuffer pixel (u,v), visited row-major, a ray is marched
// through depth d = 0..N-1 along the selected view axis; the first non-zero
// voxel colour is written to the framebuffer, or 0 when the ray misses.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   start  : frame request, honoured only while idle
//   axis   : view axis (0=Z, 1=Y, 2=X, 3 behaves as 0), latched at start
//   bus    : voxel write port + framebuffer write handshake (master side)
//   busy   : high whenever a frame is in progress (any state but IDLE)
//   done   : single-cycle pulse when the last pixel has been accepted
// ----------------------------------------------------------------------------
module voxel_raster #(
    parameter int GRID_BITS     = 3,
    parameter int FB_PITCH_BITS = 5,
    parameter int ADDR_W        = 12,
    parameter int COLOR_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          axis,
    voxel_raster_if.master      bus,
    output logic                busy,
    output logic                done
);

    localparam int N     = 1 << GRID_BITS;
    localparam int DEPTH = 1 << (3 * GRID_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [GRID_BITS-1:0] u, v, d;
    logic [1:0]           axis_q;
    logic [COLOR_W-1:0]   pixel;

    logic [GRID_BITS-1:0]   x, y, z;
    logic [3*GRID_BITS-1:0] rd_addr;
    logic [COLOR_W-1:0]     rd_data;
    logic                   hit, last_d, last_px;

    // ------------------------------------------------------------------
    // Voxel store: no reset, contents persist across frames and resets.
    // The read is asynchronous while the write lands on the clock edge, so
    // a same-cycle read of the written address still sees the old colour.
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.vox_we)
            mem[bus.vox_waddr] <= bus.vox_wdata;
    end

    // Map screen position and depth to voxel coordinates for the view axis.
    always_comb begin
        x = u;
        y = v;
        z = d;
        case (axis_q)
            2'd1: begin
                x = u;
                y = d;
                z = v;
            end
            2'd2: begin
                x = d;
                y = v;
                z = u;
            end
            default: ;
        endcase
    end

    assign rd_addr = {z, y, x};
    assign rd_data = mem[rd_addr];
    assign hit     = (rd_data != '0);
    assign last_d  = (d == GRID_BITS'(N - 1));
    assign last_px = (u == GRID_BITS'(N - 1)) && (v == GRID_BITS'(N - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = SCAN;
            SCAN:  if (hit || last_d) state_next = WRITE;
            WRITE: if (bus.fb_ready) state_next = last_px ? DONE : SCAN;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // The address is formed straight from the pixel counters, which are
    // stable for the whole WRITE state and zero while held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        bus.fb_we   = (state == WRITE);
        bus.fb_addr = (ADDR_W'(v) << FB_PITCH_BITS) + ADDR_W'(u);
        bus.fb_data = pixel;
    end

    // ------------------------------------------------------------------
    // Counters, axis latch and captured pixel colour.
    // The pixel counters wrap naturally after the last pixel, so they are
    // already back at (0,0) when the frame completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u      <= '0;
            v      <= '0;
            d      <= '0;
            axis_q <= 2'd0;
            pixel  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        axis_q <= (axis == 2'd3) ? 2'd0 : axis;
                        u      <= '0;
                        v      <= '0;
                        d      <= '0;
                    end
                end
                SCAN: begin
                    if (hit)
                        pixel <= rd_data;
                    else if (last_d)
                        pixel <= '0;
                    else
                        d <= d + 1'b1;
                end
                WRITE: begin
                    if (bus.fb_ready) begin
                        d <= '0;
                        u <= u + 1'b1;
                        if (u == GRID_BITS'(N - 1))
                            v <= v + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_raster.sv
// ----------------------------------------------------------------------------
// tb_voxel_raster
// Self-checking bench for voxel_raster. A reference image is computed from a
// shadow copy of the voxel store by marching each ray in plain arithmetic;
// a negedge monitor collects accepted framebuffer writes, scan latency and
// handshake stability, and each frame is compared against the reference.
// ----------------------------------------------------------------------------
module tb_voxel_raster;

    localparam int GB = 3;
    localparam int N  = 8;
    localparam int PB = 5;
    localparam int AW = 12;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] axis;
    logic       busy;
    logic       done;

    voxel_raster_if #(.GRID_BITS(GB), .ADDR_W(AW), .COLOR_W(CW)) bus ();

    voxel_raster #(
        .GRID_BITS(GB), .FB_PITCH_BITS(PB), .ADDR_W(AW), .COLOR_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .axis  (axis),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Shadow voxel store, index z*64 + y*8 + x.
    int mem_m [512];

    function automatic int ray(input int ax, input int u, input int v, output int k);
        int x, y, z;
        for (int dd = 0; dd < N; dd++) begin
            if (ax == 1)      begin x = u;  y = dd; z = v;  end
            else if (ax == 2) begin x = dd; y = v;  z = u;  end
            else              begin x = u;  y = v;  z = dd; end
            if (mem_m[z*64 + y*8 + x] != 0) begin
                k = dd + 1;
                return mem_m[z*64 + y*8 + x];
            end
        end
        k = N;
        return 0;
    endfunction

    // ---------------- monitor ----------------
    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   wr_scan_q[$];
    int   wr_wecyc_q[$];
    int   scan_cnt = 0;
    int   we_cyc   = 0;
    int   done_cnt = 0;
    logic prev_we  = 1'b0;
    logic prev_rdy = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [CW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            scan_cnt = 0;
            we_cyc   = 0;
            prev_we  = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_we && prev_rdy)
                chk("we_gap", bus.fb_we, 0);
            if (bus.fb_we) begin
                if (prev_we && !prev_rdy) begin
                    chk("stall_addr", bus.fb_addr, prev_addr);
                    chk("stall_data", bus.fb_data, prev_data);
                end
                we_cyc++;
                if (bus.fb_ready) begin
                    wr_addr_q.push_back(int'(bus.fb_addr));
                    wr_data_q.push_back(int'(bus.fb_data));
                    wr_scan_q.push_back(scan_cnt);
                    wr_wecyc_q.push_back(we_cyc);
                    scan_cnt = 0;
                    we_cyc   = 0;
                end
            end else if (busy && !done) begin
                scan_cnt++;
            end
            if (done) done_cnt++;
            prev_we   = bus.fb_we;
            prev_rdy  = bus.fb_ready;
            prev_addr = bus.fb_addr;
            prev_data = bus.fb_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    // All drivers run at posedge+#1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vox_write(input int x, input int y, input int z, input int c);
        bus.vox_we    = 1'b1;
        bus.vox_waddr = 9'((z << 6) | (y << 3) | x);
        bus.vox_wdata = 8'(c);
        tick();
        bus.vox_we    = 1'b0;
        mem_m[z*64 + y*8 + x] = c;
    endtask

    task automatic clear_queues();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_scan_q.delete();
        wr_wecyc_q.delete();
        done_cnt = 0;
    endtask

    // mode: 0 = always ready, 1 = random backpressure, 2 = stall first write 5 cycles
    // mid : apply a host voxel write and a stray start partway through the frame
    task automatic run_frame(input string name, input int ax, input int mode, input bit mid,
                             output int first_we_cycles);
        int e_c[64];
        int e_k[64];
        int kk;
        int stall_left;
        bit mid_done;
        int eff_ax;
        eff_ax = (ax == 3) ? 0 : ax;
        for (int i = 0; i < 64; i++) e_c[i] = ray(eff_ax, i % 8, i / 8, e_k[i]);
        clear_queues();
        stall_left = 5;
        mid_done   = 1'b0;
        first_we_cycles = 0;
        axis  = 2'(ax);
        start = 1'b1;
        bus.fb_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 6000 && done_cnt == 0; cyc++) begin
            start = 1'b0;
            bus.vox_we = 1'b0;
            case (mode)
                1: bus.fb_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.fb_we && stall_left > 0) begin
                        bus.fb_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.fb_ready = 1'b1;
                    end
                end
                default: bus.fb_ready = 1'b1;
            endcase
            if (mid && !mid_done && wr_addr_q.size() >= 10) begin
                mid_done = 1'b1;
                start = 1'b1;
                // Pixel 63 ray not yet started: must see the new colour.
                bus.vox_we    = 1'b1;
                bus.vox_waddr = 9'((3 << 6) | (7 << 3) | 7);
                bus.vox_wdata = 8'h55;
                mem_m[3*64 + 7*8 + 7] = 8'h55;
                for (int i = 11; i < 64; i++) e_c[i] = ray(eff_ax, i % 8, i / 8, e_k[i]);
            end
            tick();
        end
        start = 1'b0;
        bus.vox_we = 1'b0;
        if (mid) begin
            // Pixel 0 already written: changing its voxel now must not matter.
            vox_write(0, 0, 0, 8'h66);
        end
        repeat (3) tick();
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_nwrites"}, wr_addr_q.size(), 64);
        for (int i = 0; i < 64 && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), wr_addr_q[i], (i / 8) * 32 + (i % 8));
            chk($sformatf("%s_data%0d", name, i), wr_data_q[i], e_c[i]);
            chk($sformatf("%s_scan%0d", name, i), wr_scan_q[i], e_k[i]);
        end
        if (wr_wecyc_q.size() > 0) first_we_cycles = wr_wecyc_q[0];
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wc;
        int kk;
        bit hit20;
        reset = 1'b1;
        start = 1'b0;
        axis  = 2'd0;
        bus.vox_we    = 1'b0;
        bus.vox_waddr = '0;
        bus.vox_wdata = '0;
        bus.fb_ready  = 1'b0;
        for (int i = 0; i < 512; i++) mem_m[i] = 0;
        repeat (3) tick();
        chk("rst_fb_we",   bus.fb_we,   0);
        chk("rst_busy",    busy,        0);
        chk("rst_done",    done,        0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        reset = 1'b0;
        tick();

        // Clear store, empty frame.
        for (int i = 0; i < 512; i++) vox_write(i % 8, (i / 8) % 8, i / 64, 0);
        run_frame("clear", 0, 0, 1'b0, wc);

        // Nearest of two voxels on one ray wins.
        vox_write(2, 3, 5, 8'h11);
        vox_write(2, 3, 1, 8'h22);
        chk("model_pix98", ray(0, 2, 3, kk), 8'h22);
        run_frame("near", 0, 0, 1'b0, wc);
        vox_write(2, 3, 5, 0);
        vox_write(2, 3, 1, 0);

        // Single voxel viewed along each axis.
        vox_write(1, 4, 6, 8'h7F);
        run_frame("ax1", 1, 0, 1'b0, wc);
        run_frame("ax2", 2, 0, 1'b0, wc);
        run_frame("ax3", 3, 0, 1'b0, wc);

        // Backpressure on the first pixel.
        run_frame("stall", 0, 2, 1'b0, wc);
        chk("stall_we_cycles", wc, 6);

        // Random scenes with random backpressure.
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 60; j++)
                vox_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3), 1, 1'b0, wc);
        end

        // Host write and stray start mid-frame.
        vox_write(0, 0, 0, 8'h33);
        run_frame("mid", 0, 1, 1'b1, wc);

        // Reset while pixel 20 is waiting in WRITE.
        clear_queues();
        axis  = 2'd0;
        start = 1'b1;
        bus.fb_ready = 1'b1;
        tick();
        start = 1'b0;
        hit20 = 1'b0;
        for (int cyc = 0; cyc < 3000 && !hit20; cyc++) begin
            if (wr_addr_q.size() == 20 && bus.fb_we) begin
                hit20 = 1'b1;
                bus.fb_ready = 1'b0;
            end else begin
                tick();
            end
        end
        chk("rst20_reached", hit20, 1);
        chk("rst20_addr", bus.fb_addr, 68);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst20_fb_we",   bus.fb_we,   0);
        chk("rst20_busy",    busy,        0);
        chk("rst20_fb_addr", bus.fb_addr, 0);
        chk("rst20_fb_data", bus.fb_data, 0);
        chk("rst20_nwrites", wr_addr_q.size(), 20);
        @(posedge clk);
        tick();
        reset = 1'b0;
        tick();
        run_frame("after_rst", 0, 0, 1'b0, wc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voxel_raster.md
VOXEL_RASTER -- requirements
Module: voxel_raster

Interface
REQ-001 Parameter GRID_BITS, 3, log2 of grid edge N (N=8); voxel grid is N x N x N.
REQ-002 Parameter FB_PITCH_BITS, 5, log2 of framebuffer row pitch in pixels (32).
REQ-003 Parameter ADDR_W, 12, framebuffer address width.
REQ-004 Parameter COLOR_W, 8, voxel/pixel colour width; colour 0 means empty voxel / background.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  frame request; sampled only in IDLE.
REQ-008 axis  input  2  view axis: 0=Z, 1=Y, 2=X, 3 treated as 0; latched at start.
REQ-009 vox_we  input  1  voxel store write enable.
REQ-010 vox_waddr  input  3*GRID_BITS  voxel address {z,y,x}.
REQ-011 vox_wdata  input  COLOR_W  voxel colour to store.
REQ-012 fb_we  output  1  framebuffer write request.
REQ-013 fb_addr  output  ADDR_W  framebuffer pixel address.
REQ-014 fb_data  output  COLOR_W  framebuffer pixel colour.
REQ-015 fb_ready  input  1  framebuffer accepts write this cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at frame completion.

Function
REQ-018 Internal voxel store SHALL be N^3 x COLOR_W, one write port (vox_we), one read port used by scanner; host writes accepted in any state.
REQ-019 Scanner read of an address written the same cycle SHALL return the pre-write value.
REQ-020 FSM states SHALL be IDLE, SCAN, WRITE, DONE.
REQ-021 IDLE -> SCAN when start=1; axis latched, pixel (u,v)=(0,0), depth d=0; start outside IDLE ignored.
REQ-022 Pixels SHALL be visited row-major: u increments 0..N-1, then v increments; exactly N*N framebuffer writes per frame.
REQ-023 Ray mapping: axis 0 -> (x=u,y=v,z=d); axis 1 -> (x=u,y=d,z=v); axis 2 -> (x=d,y=v,z=u).
REQ-024 SCAN SHALL read one voxel per cycle, d from 0 upward; first nonzero colour ends the ray (nearest-wins).
REQ-025 Hit at depth k: WRITE entered after k+1 SCAN cycles, fb_data = that colour; miss: WRITE after N SCAN cycles, fb_data = 0.
REQ-026 In WRITE, fb_we=1 with fb_addr = v*2^FB_PITCH_BITS + u (truncated to ADDR_W) and fb_data held stable until a rising edge with fb_ready=1.
REQ-027 On accepted write: if (u,v)=(N-1,N-1) -> DONE, else advance pixel, d=0, -> SCAN; fb_we deasserted for at least one cycle between pixels.
REQ-028 DONE lasts one cycle with done=1, then IDLE; start in DONE ignored.
REQ-029 fb_ready held low SHALL stall indefinitely in WRITE with no state change; fb_ready high outside WRITE has no effect.

Reset
REQ-030 reset SHALL force IDLE, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0, counters 0, axis latch 0, immediately and mid-frame without completing the pending write.
REQ-031 Voxel store SHALL NOT be cleared by reset; contents undefined at power-up.

Verification
VER-001 Clear store (512 writes of 0), start axis=0, fb_ready=1 -> 64 writes, addrs 0..7,32..39,...,224..231, all data 0, done pulse once, each pixel after 8 SCAN cycles.
VER-002 Voxels (x=2,y=3,z=5)=0x11 and (2,3,1)=0x22, axis 0 -> addr 98 gets 0x22 after 2 SCAN cycles; all other pixels 0.
VER-003 Single voxel (x=1,y=4,z=6)=0x7F, axis 1 -> addr 193 (v=6,u=1)=0x7F; axis 2 -> addr 134 (v=4,u=6)=0x7F; axis 3 matches axis 0 (addr 129).
VER-004 fb_ready low for 5 cycles on pixel 0 -> fb_we, fb_addr, fb_data stable 6 cycles, single accepted write, frame completes normally.
VER-005 reset asserted during WRITE of pixel 20 -> fb_we=0 same cycle, busy=0; new start restarts at addr 0; voxel contents intact.
VER-006 start pulsed while busy and vox_we to a voxel mid-frame -> no restart; scanner sees new colour only for rays read after the write cycle.
